// File: rtl/udatapath_pipe.sv
// Two-stage micro-datapath: EX (operand mux, ALU, shifter) -> WB (register write).
// Define UDATAPATH_PIPE_FWD_EN to bypass the pending WB result instead of interlocking.
module udatapath_pipe #(
  parameter int                         DATAWIDTH_BUS = 8,
  parameter int                         NUM_REGS      = 4,
  parameter int                         SEL_W         = 3,
  parameter logic [DATAWIDTH_BUS-1:0]   DATA_FIXED_0  = DATAWIDTH_BUS'(8'h09),
  parameter logic [DATAWIDTH_BUS-1:0]   DATA_FIXED_1  = DATAWIDTH_BUS'(8'h0F),
  parameter int                         OUT_REG       = 3
) (
  input  logic                     uDATAPATH_CLOCK_50,
  input  logic                     uDATAPATH_RESET_InHigh,
  input  logic                     uDATAPATH_issue_valid_In,
  output logic                     uDATAPATH_issue_ready_Out,
  input  logic [SEL_W-1:0]         uDATAPATH_srcA_InBUS,
  input  logic [SEL_W-1:0]         uDATAPATH_srcB_InBUS,
  input  logic [SEL_W-1:0]         uDATAPATH_dst_InBUS,
  input  logic [3:0]               uDATAPATH_aluop_InBUS,
  input  logic [1:0]               uDATAPATH_shiftop_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] uDATAPATH_ext_InBUS,
  output logic [DATAWIDTH_BUS-1:0] uDATAPATH_data_OutBUS,
  output logic                     uDATAPATH_wb_valid_Out,
  output logic                     uDATAPATH_overflow_OutLow,
  output logic                     uDATAPATH_carry_OutLow,
  output logic                     uDATAPATH_negative_OutLow,
  output logic                     uDATAPATH_zero_OutLow
);

  localparam int W      = DATAWIDTH_BUS;
  localparam int REG_AW = $clog2(NUM_REGS);

  localparam logic [SEL_W-1:0]  SEL_NREG = SEL_W'(NUM_REGS);
  localparam logic [SEL_W-1:0]  SEL_FIX0 = SEL_W'(NUM_REGS);
  localparam logic [SEL_W-1:0]  SEL_FIX1 = SEL_W'(NUM_REGS + 1);
  localparam logic [SEL_W-1:0]  SEL_EXT  = SEL_W'(NUM_REGS + 2);
  localparam logic [REG_AW-1:0] OUT_IDX  = REG_AW'(OUT_REG);

  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_X = {{W{1'b0}}, 1'b1};

  localparam logic [3:0] ALU_A   = 4'd0;
  localparam logic [3:0] ALU_B   = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_NOT = 4'd7;
  localparam logic [3:0] ALU_INC = 4'd8;
  localparam logic [3:0] ALU_DEC = 4'd9;
  localparam logic [3:0] ALU_ADC = 4'd10;

  logic clk, rst;
  assign clk = uDATAPATH_CLOCK_50;
  assign rst = uDATAPATH_RESET_InHigh;

  logic [W-1:0]      regs_q [NUM_REGS];
  logic [W-1:0]      regs_d [NUM_REGS];
  logic [W-1:0]      ext_q, ext_d;
  logic [W-1:0]      result_q, result_d;
  logic [SEL_W-1:0]  dst_q, dst_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d, cry_q, cry_d, neg_q, neg_d, zro_q, zro_d;

  logic              pend_wr, haz_a, haz_b, accept;
  logic [W-1:0]      opa, opb, alu_res, shifted;
  logic [W:0]        wide;
  logic              alu_c, alu_v;

  function automatic logic is_gpr(input logic [SEL_W-1:0] sel);
    return sel < SEL_NREG;
  endfunction

  function automatic logic [W-1:0] read_sel(input logic [SEL_W-1:0] sel);
    if (is_gpr(sel))          return regs_q[sel[REG_AW-1:0]];
    else if (sel == SEL_FIX0) return DATA_FIXED_0;
    else if (sel == SEL_FIX1) return DATA_FIXED_1;
    else if (sel == SEL_EXT)  return ext_q;
    else                      return '0;
  endfunction

  function automatic logic add_ovf(input logic [W-1:0] a, b, r);
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  function automatic logic sub_ovf(input logic [W-1:0] a, b, r);
    return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  // A pending WB that targets a general register this op reads is a hazard.
  assign pend_wr = valid_q && is_gpr(dst_q);
  assign haz_a   = pend_wr && (uDATAPATH_srcA_InBUS == dst_q);
  assign haz_b   = pend_wr && (uDATAPATH_srcB_InBUS == dst_q);

`ifdef UDATAPATH_PIPE_FWD_EN
  assign uDATAPATH_issue_ready_Out = 1'b1;
  assign opa = haz_a ? result_q : read_sel(uDATAPATH_srcA_InBUS);
  assign opb = haz_b ? result_q : read_sel(uDATAPATH_srcB_InBUS);
`else
  assign uDATAPATH_issue_ready_Out = !(uDATAPATH_issue_valid_In && (haz_a || haz_b));
  assign opa = read_sel(uDATAPATH_srcA_InBUS);
  assign opb = read_sel(uDATAPATH_srcB_InBUS);
`endif

  assign accept = uDATAPATH_issue_valid_In && uDATAPATH_issue_ready_Out;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (uDATAPATH_aluop_InBUS)
      ALU_A:   alu_res = opa;
      ALU_B:   alu_res = opb;
      ALU_ADD: begin
        wide    = {1'b0, opa} + {1'b0, opb};
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
        alu_v   = add_ovf(opa, opb, alu_res);
      end
      ALU_SUB: begin
        wide    = {1'b0, opa} - {1'b0, opb};
        alu_res = wide[W-1:0];
        alu_c   = ~wide[W];
        alu_v   = sub_ovf(opa, opb, alu_res);
      end
      ALU_AND: alu_res = opa & opb;
      ALU_OR:  alu_res = opa | opb;
      ALU_XOR: alu_res = opa ^ opb;
      ALU_NOT: alu_res = ~opa;
      ALU_INC: begin
        wide    = {1'b0, opa} + ONE_X;
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
        alu_v   = add_ovf(opa, ONE, alu_res);
      end
      ALU_DEC: begin
        wide    = {1'b0, opa} - ONE_X;
        alu_res = wide[W-1:0];
        alu_c   = ~wide[W];
        alu_v   = sub_ovf(opa, ONE, alu_res);
      end
      ALU_ADC: begin
        wide    = {1'b0, opa} + {1'b0, opb} + ONE_X;
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
        alu_v   = add_ovf(opa, opb, alu_res);
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (uDATAPATH_shiftop_InBUS)
      2'b01:   shifted = {alu_res[W-2:0], 1'b0};
      2'b10:   shifted = {1'b0, alu_res[W-1:1]};
      2'b11:   shifted = {alu_res[W-1], alu_res[W-1:1]};
      default: shifted = alu_res;
    endcase
  end

  always_comb begin
    ext_d    = uDATAPATH_ext_InBUS;
    valid_d  = accept;
    result_d = accept ? shifted : result_q;
    dst_d    = accept ? uDATAPATH_dst_InBUS : dst_q;
    ovf_d    = accept ? alu_v : ovf_q;
    cry_d    = accept ? alu_c : cry_q;
    neg_d    = accept ? shifted[W-1] : neg_q;
    zro_d    = accept ? (shifted == '0) : zro_q;
    regs_d   = regs_q;
    if (pend_wr) regs_d[dst_q[REG_AW-1:0]] = result_q;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is architecturally visible after reset, so it is reset too.
      regs_q   <= '{default: '0};
      ext_q    <= '0;
      result_q <= '0;
      dst_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cry_q    <= 1'b0;
      neg_q    <= 1'b0;
      zro_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      ext_q    <= ext_d;
      result_q <= result_d;
      dst_q    <= dst_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      cry_q    <= cry_d;
      neg_q    <= neg_d;
      zro_q    <= zro_d;
    end
  end

  assign uDATAPATH_data_OutBUS     = regs_q[OUT_IDX];
  assign uDATAPATH_wb_valid_Out    = valid_q;
  assign uDATAPATH_overflow_OutLow = ~ovf_q;
  assign uDATAPATH_carry_OutLow    = ~cry_q;
  assign uDATAPATH_negative_OutLow = ~neg_q;
  assign uDATAPATH_zero_OutLow     = ~zro_q;

endmodule
